sd4_align_accumulator: RTL and testbench
========================================

// Module: sd4_align_accumulator
// PURPOSE
//  Sequential block-floating-point accumulator feeding normalization. Accepts one
//  sign/mantissa/exponent product term per cycle (valid/ready) and keeps a running
//  max exponent, realigning the accumulator whenever a larger exponent arrives.
//  On the last term it presents signed_sum[19:0] and exp_max[5:0] to normalization.
//  Value convention: result = signed_sum * 2^(exp_max-10).
// PARAMETERS
//  MANT_W    11   unsigned term mantissa width (1.10 fixed point)
//  ACC_W     20   signed accumulator width (= normalization signed_sum width)
//  EXP_W     6    signed exponent width
//  MAX_TERMS 256  guaranteed overflow-free terms per vector (bits ACC_W-2..MANT_W = headroom)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-high
//  in_valid   in   1       term valid
//  in_ready   out  1       block can accept term
//  in_sign    in   1       term sign (1 = negative)
//  in_mant    in   MANT_W  term magnitude
//  in_exp     in   EXP_W   term exponent, signed
//  in_last    in   1       final term of vector
//  out_valid  out  1       result valid
//  out_ready  in   1       normalization consumes result
//  signed_sum out  ACC_W   accumulated two's-complement sum
//  exp_max    out  EXP_W   max exponent of nonzero terms, signed
//  out_ovf    out  1       sticky: signed add overflow occurred in this vector
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, signed_sum=0, exp_max=-32, out_ovf=0, term_cnt=0.
//  - Term accepted when in_valid & in_ready. in_ready = (state != OUT).
//  - FSM: IDLE (no terms yet) -> ACC on first accept; IDLE/ACC -> OUT on accept with in_last;
//    OUT -> IDLE when out_valid & out_ready. A single-term vector goes IDLE->OUT.
//  - Entering a vector (accept in IDLE): acc=0, max=-32, ovf=0 before the term is applied.
//  - Term with in_mant==0: contributes 0, does not update max, still counts/ends vector.
//  - Term t = in_sign ? -m : m (ACC_W-bit two's complement), where
//    if in_exp <= max: m = in_mant >> (max-in_exp) (logical, truncating; shift >= ACC_W -> 0),
//      acc <= acc + t.
//    if in_exp > max: acc <= (acc >>> (in_exp-max)) + in_mant-based t (unshifted),
//      max <= in_exp. Arithmetic shift floors; shift >= ACC_W-1 -> 0 or -1 by sign.
//  - Shift amount is computed at EXP_W+1 bits (range 0..63); no wrap.
//  - Add wraps mod 2^ACC_W; out_ovf set if operands have the same sign and the result sign differs.
//  - Latency: out_valid rises the cycle after the in_last accept; signed_sum/exp_max/out_ovf
//    stay stable while out_valid & !out_ready. in_ready returns 1 the cycle after the out handshake.
//  - No rounding; truncated bits are lost. All-zero vector -> signed_sum=0, exp_max=-32.
//  - rst asserted mid-vector or in OUT: abandon everything, return to reset values next cycle.
//  - Outputs registered; no combinational path from in_* to out_*.
// TESTING
//  1 (+1024,e0),(+1024,e0,last) -> signed_sum=2048, exp_max=0, ovf=0, out_valid 1 cycle after last.
//  2 (+1024,e0),(+1024,e2,last) -> realign: 256+1024=1280, exp_max=2.
//  3 (+1024,e3),(+1024,e0),(-1536,e3,last) -> 1024+128-1536=-384 (0xFFE80), exp_max=3.
//  4 (+1024,e0),(+2047,e-30,last) -> shift 30 gives 0: sum=1024, exp_max=0; also e31 then e-32 -> shift 63, no wrap.
//  5 257 terms of (+2047,e0) -> out_ovf=1; 256 terms -> 524032, ovf=0.
//  6 hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; rst mid-vector -> next vector unaffected.

Source files
------------

// File: rtl/sd4_align_accumulator.sv
// Block-floating-point accumulator: sums sign/mantissa/exponent terms against a
// running max exponent, realigning the sum whenever a larger exponent arrives.
module sd4_align_accumulator #(
    parameter int MANT_W    = 11,
    parameter int ACC_W     = 20,
    parameter int EXP_W     = 6,
    parameter int MAX_TERMS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  signed_sum,
    output logic [EXP_W-1:0]  exp_max,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(MAX_TERMS) + 1;
    localparam logic [EXP_W-1:0] MIN_EXP   = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [EXP_W:0]   SH_FULL   = (EXP_W+1)'(ACC_W);
    localparam logic [EXP_W:0]   SH_SIGNED = (EXP_W+1)'(ACC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [EXP_W-1:0]   max_q, max_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;

    logic               accept;
    logic [ACC_W-1:0]   base_acc;
    logic [EXP_W-1:0]   base_max;
    logic               base_ovf;
    logic [EXP_W:0]     exp_ext, max_ext, shift_amt;
    logic               exp_gt, mant_zero;
    logic [ACC_W-1:0]   mant_ext, mag, term, aligned_acc, sum;
    logic               add_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            max_q      <= MIN_EXP;
            ovf_q      <= 1'b0;
            term_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
            ovf_q      <= ovf_d;
            term_cnt_q <= term_cnt_d;
        end
    end

    // A term accepted in IDLE opens a fresh vector, so it sees a cleared accumulator.
    always_comb begin
        accept    = in_valid && in_ready;
        base_acc  = (state_q == S_IDLE) ? '0 : acc_q;
        base_max  = (state_q == S_IDLE) ? MIN_EXP : max_q;
        base_ovf  = (state_q == S_IDLE) ? 1'b0 : ovf_q;
        mant_zero = (in_mant == '0);

        exp_ext   = {in_exp[EXP_W-1], in_exp};
        max_ext   = {base_max[EXP_W-1], base_max};
        exp_gt    = $signed(exp_ext) > $signed(max_ext);
        shift_amt = exp_gt ? (exp_ext - max_ext) : (max_ext - exp_ext);
        mant_ext  = {{(ACC_W-MANT_W){1'b0}}, in_mant};

        aligned_acc = base_acc;
        mag         = '0;
        if (!mant_zero) begin
            if (exp_gt) begin
                if (shift_amt >= SH_SIGNED) begin
                    aligned_acc = {ACC_W{base_acc[ACC_W-1]}};
                end else begin
                    aligned_acc = $signed(base_acc) >>> shift_amt;
                end
                mag = mant_ext;
            end else if (shift_amt < SH_FULL) begin
                mag = mant_ext >> shift_amt;
            end
        end

        term    = in_sign ? (~mag + 1'b1) : mag;
        sum     = aligned_acc + term;
        add_ovf = (aligned_acc[ACC_W-1] == term[ACC_W-1]) &&
                  (sum[ACC_W-1] != aligned_acc[ACC_W-1]);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        max_d      = max_q;
        ovf_d      = ovf_q;
        term_cnt_d = term_cnt_q;

        if (accept) begin
            acc_d      = sum;
            max_d      = (!mant_zero && exp_gt) ? in_exp : base_max;
            ovf_d      = base_ovf | add_ovf;
            term_cnt_d = ((state_q == S_IDLE) ? '0 : term_cnt_q) + 1'b1;
            state_d    = in_last ? S_OUT : S_ACC;
        end else if (state_q == S_OUT && out_ready) begin
            state_d = S_IDLE;
        end
    end

    assign in_ready   = (state_q != S_OUT);
    assign out_valid  = (state_q == S_OUT);
    assign signed_sum = acc_q;
    assign exp_max    = max_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_sd4_align_accumulator.sv
// Self-checking bench for sd4_align_accumulator: directed cases plus random
// vectors compared against an arithmetic reference model.
module tb_sd4_align_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sign, in_last, out_ready;
    logic [10:0] in_mant;
    logic [5:0]  in_exp;
    logic        in_ready, out_valid, out_ovf;
    logic [19:0] signed_sum;
    logic [5:0]  exp_max;

    int total = 0;
    int bad   = 0;

    int t_sign[$];
    int t_mant[$];
    int t_exp[$];

    always #5 clk = ~clk;

    sd4_align_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .signed_sum (signed_sum),
        .exp_max    (exp_max),
        .out_ovf    (out_ovf)
    );

    // Value-level model: true integer sums, floor division for realignment,
    // overflow judged by whether the true sum leaves the 20-bit signed range.
    function automatic void model(output int e_sum, output int e_max, output bit e_ovf);
        longint acc = 0;
        int     mx  = -32;
        bit     ovf = 0;
        foreach (t_mant[i]) begin
            longint term, base, s, d;
            int sh;
            if (t_mant[i] != 0) begin
                if (t_exp[i] <= mx) begin
                    sh   = mx - t_exp[i];
                    term = (sh >= 20) ? 0 : (t_mant[i] / (1 << sh));
                    base = acc;
                end else begin
                    sh = t_exp[i] - mx;
                    if (sh >= 19) begin
                        base = (acc < 0) ? -1 : 0;
                    end else begin
                        d    = longint'(1) << sh;
                        base = acc / d;
                        if (acc < 0 && base * d != acc) base = base - 1;
                    end
                    term = t_mant[i];
                    mx   = t_exp[i];
                end
                if (t_sign[i] != 0) term = -term;
                s = base + term;
                if (s > 524287 || s < -524288) ovf = 1;
                acc = ((s + 524288 + 1048576) % 1048576) - 524288;
            end
        end
        e_sum = int'(acc);
        e_max = mx;
        e_ovf = ovf;
    endfunction

    task automatic clear_terms();
        t_sign.delete();
        t_mant.delete();
        t_exp.delete();
    endtask

    task automatic add_term(input int s, input int m, input int e);
        t_sign.push_back(s);
        t_mant.push_back(m);
        t_exp.push_back(e);
    endtask

    task automatic idle_inputs();
        in_valid = 0;
        in_sign  = 0;
        in_mant  = '0;
        in_exp   = '0;
        in_last  = 0;
    endtask

    // Drives the queued vector (optionally with bubbles), then holds off the
    // consumer for `hold` cycles before completing the output handshake.
    task automatic run_vector(input string name, input int hold, input bit gaps);
        int          e_sum, e_max;
        bit          e_ovf;
        logic [19:0] want_sum;
        logic [5:0]  want_max;
        int          n;
        model(e_sum, e_max, e_ovf);
        want_sum = e_sum[19:0];
        want_max = e_max[5:0];
        n = t_mant.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle_inputs();
                @(posedge clk); #1;
            end
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s accept_ready term %0d: in_ready=%b out_valid=%b want 1/0",
                         name, i, in_ready, out_valid);
            end
            in_valid = 1;
            in_sign  = (t_sign[i] != 0);
            in_mant  = t_mant[i][10:0];
            in_exp   = t_exp[i][5:0];
            in_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        idle_inputs();
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s latency: out_valid=%b in_ready=%b want 1/0", name, out_valid, in_ready);
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || signed_sum !== want_sum || exp_max !== want_max) begin
                bad++;
                $display("[TB] FAIL %s hold cycle %0d: valid=%b ready=%b sum=%h exp=%h want 1/0 %h %h",
                         name, c, out_valid, in_ready, signed_sum, exp_max, want_sum, want_max);
            end
        end
        total++;
        if (signed_sum !== want_sum || exp_max !== want_max || out_ovf !== e_ovf) begin
            bad++;
            $display("[TB] FAIL %s result: sum=%h exp=%h ovf=%b want %h %h %b",
                     name, signed_sum, exp_max, out_ovf, want_sum, want_max, e_ovf);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || signed_sum !== 20'h0 ||
            exp_max !== 6'h20 || out_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s: valid=%b ready=%b sum=%h exp=%h ovf=%b want 0 1 00000 20 0",
                     name, out_valid, in_ready, signed_sum, exp_max, out_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_reset_values("reset_state");
    endtask

    task automatic test_directed();
        clear_terms(); add_term(0, 1024, 0); add_term(0, 1024, 0);
        run_vector("equal_exp", 0, 0);
        clear_terms(); add_term(0, 1024, 0); add_term(0, 1024, 2);
        run_vector("realign_up", 0, 0);
        clear_terms(); add_term(0, 1024, 3); add_term(0, 1024, 0); add_term(1, 1536, 3);
        run_vector("mixed_sign", 0, 0);
        clear_terms(); add_term(0, 1024, 0); add_term(0, 2047, -30);
        run_vector("shift_30", 0, 0);
        clear_terms(); add_term(0, 1024, 31); add_term(0, 2047, -32);
        run_vector("shift_63", 0, 0);
        clear_terms(); add_term(1, 2047, -32); add_term(0, 5, 31);
        run_vector("neg_realign_63", 0, 0);
        clear_terms(); add_term(0, 777, -5);
        run_vector("single_term", 0, 0);
    endtask

    task automatic test_zero_terms();
        clear_terms(); add_term(0, 0, 10); add_term(1, 0, -3); add_term(0, 0, 0);
        run_vector("all_zero", 0, 0);
        clear_terms(); add_term(0, 100, 1); add_term(0, 0, 20); add_term(1, 50, 1);
        run_vector("zero_no_max", 0, 0);
    endtask

    task automatic test_overflow();
        clear_terms();
        for (int i = 0; i < 256; i++) add_term(0, 2047, 0);
        run_vector("terms_256", 0, 0);
        clear_terms();
        for (int i = 0; i < 257; i++) add_term(0, 2047, 0);
        run_vector("terms_257", 0, 0);
        clear_terms(); add_term(0, 9, 0);
        run_vector("ovf_cleared", 0, 0);
    endtask

    task automatic test_backpressure();
        clear_terms(); add_term(0, 1500, 4); add_term(1, 300, 2); add_term(0, 11, 5);
        run_vector("hold5", 5, 0);
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_sign = 0; in_mant = 11'd2000; in_exp = 6'd7; in_last = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        check_reset_values("reset_mid_vector");
        clear_terms(); add_term(0, 3, 0); add_term(0, 4, 0);
        run_vector("after_reset_mid", 0, 0);
        in_valid = 1; in_mant = 11'd500; in_exp = 6'd1; in_last = 1;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_reset_values("reset_in_out");
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 40; v++) begin
            int len;
            bool_wide: begin
                bit wide;
                wide = ($urandom_range(0, 4) == 0);
                len  = $urandom_range(1, 8);
                clear_terms();
                for (int i = 0; i < len; i++) begin
                    int m, e;
                    m = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 2047);
                    e = wide ? $urandom_range(0, 63) - 32 : $urandom_range(0, 12) - 6;
                    add_term($urandom_range(0, 1), m, e);
                end
                run_vector("random", $urandom_range(0, 2), $urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_terms();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
